// File: rtl/sel_dist_1_4_2bits_if.sv
// Producer/consumer bundle for the 1-to-4 distributor. Build option DIST_LAST_EN
// adds the IN_LAST / OUT_LAST packet-boundary signals.
interface sel_dist_1_4_2bits_if #(
  parameter int W = 2
);
  logic [W-1:0] IN;
  logic         IN_VALID;
  logic         IN_READY;
  logic [1:0]   SEL;
  logic         AUTO;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic [W-1:0] D;
  logic [3:0]   OUT_VALID;
  logic [3:0]   OUT_READY;
  logic [1:0]   PTR;
`ifdef DIST_LAST_EN
  logic         IN_LAST;
  logic [3:0]   OUT_LAST;

  modport master (
    output IN, IN_VALID, SEL, AUTO, OUT_READY, IN_LAST,
    input  IN_READY, A, B, C, D, OUT_VALID, PTR, OUT_LAST
  );
  modport slave (
    input  IN, IN_VALID, SEL, AUTO, OUT_READY, IN_LAST,
    output IN_READY, A, B, C, D, OUT_VALID, PTR, OUT_LAST
  );
`else
  modport master (
    output IN, IN_VALID, SEL, AUTO, OUT_READY,
    input  IN_READY, A, B, C, D, OUT_VALID, PTR
  );
  modport slave (
    input  IN, IN_VALID, SEL, AUTO, OUT_READY,
    output IN_READY, A, B, C, D, OUT_VALID, PTR
  );
`endif
endinterface

// File: rtl/sel_dist_1_4_2bits.sv
// Registered 1-to-4 distributor: one valid/ready input routed to one of four single-entry
// output slots, by SEL or by a round-robin pointer. Build option DIST_LAST_EN adds packet framing.
module sel_dist_1_4_2bits #(
  parameter int W         = 2,
  parameter int RESET_PTR = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  sel_dist_1_4_2bits_if.slave  bus
);
  localparam logic [1:0] PTR_INIT = 2'(RESET_PTR);

  logic [W-1:0] slot_p1 [4];
  logic [3:0]   vld_p1;
  logic [1:0]   ptr_p1;
`ifdef DIST_LAST_EN
  logic [3:0]   last_p1;
`endif

  logic [1:0] tgt;
  logic       in_ready;
  logic       accept;
  logic       ptr_adv;

  // Stage 0: combinational target select and accept decision
  assign tgt      = bus.AUTO ? ptr_p1 : bus.SEL;
  assign in_ready = ~vld_p1[tgt] | bus.OUT_READY[tgt];
  assign accept   = bus.IN_VALID & in_ready;
`ifdef DIST_LAST_EN
  assign ptr_adv  = accept & bus.AUTO & bus.IN_LAST;
`else
  assign ptr_adv  = accept & bus.AUTO;
`endif

  // Stage 1: slot valid flags and round-robin pointer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1 <= '0;
      ptr_p1 <= PTR_INIT;
    end else begin
      for (int i = 0; i < 4; i++) begin
        // A reload of a draining slot keeps it valid for back-to-back throughput
        if (accept && (tgt == 2'(i))) begin
          vld_p1[i] <= 1'b1;
        end else if (bus.OUT_READY[i]) begin
          vld_p1[i] <= 1'b0;
        end
      end
      if (ptr_adv) begin
        ptr_p1 <= ptr_p1 + 2'd1;
      end
    end
  end

  // Stage 1: slot data, held after drain until the next load
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) begin
        slot_p1[i] <= '0;
      end
`ifdef DIST_LAST_EN
      last_p1 <= '0;
`endif
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (tgt == 2'(i))) begin
          slot_p1[i] <= bus.IN;
`ifdef DIST_LAST_EN
          last_p1[i] <= bus.IN_LAST;
`endif
        end
      end
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.A         = slot_p1[0];
  assign bus.B         = slot_p1[1];
  assign bus.C         = slot_p1[2];
  assign bus.D         = slot_p1[3];
  assign bus.OUT_VALID = vld_p1;
  assign bus.PTR       = ptr_p1;
`ifdef DIST_LAST_EN
  assign bus.OUT_LAST  = last_p1;
`endif

endmodule
